// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Holds the frame FSM state encoding.
// Pure type definitions; no logic.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_stream_if.sv
// Word-stream handshake from the upstream FIFO into the UART transmitter.
// Wires only, no latency.
// The word is consumed on an edge where valid and ready are both high.
interface uart_tx_stream_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] data_in_i;
    logic                  data_in_valid_i;
    logic                  data_in_ready_o;

    modport master (
        output data_in_i,
        output data_in_valid_i,
        input  data_in_ready_o
    );

    modport slave (
        input  data_in_i,
        input  data_in_valid_i,
        output data_in_ready_o
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..div-1 and pulses tick_o on the last count.
// tick_o is combinational from the count register.
// No backpressure; clr_i restarts the period.
module uart_baud_cnt #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] cnt_q;

    // Compare against div-1 so an all-ones divisor never needs a wider counter.
    assign tick_o = (cnt_q == (div_i - ONE));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + ONE;
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, 1/2 stop bits.
// tx_o falls one cycle after the accept edge; frame = DIV*(1+DATA_WIDTH+P+S) cycles.
// Ready only in IDLE; a waiting word stays upstream until the frame ends.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 stop2_i,
    uart_tx_stream_if.slave      s_if,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]        LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

    uart_tx_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    tx_q, tx_d;
    logic                    par_q;
    logic                    par_en_q;
    logic                    stop2_q;
    logic [DIV_WIDTH-1:0]    div_q;
    logic                    accept;
    logic                    tick;

    assign accept               = (state_q == IDLE) && s_if.data_in_valid_i;
    assign s_if.data_in_ready_o = (state_q == IDLE) && !arst_i;
    assign busy_o               = (state_q != IDLE);
    assign tx_o                 = tx_q;

    uart_baud_cnt #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .clr_i  (accept),
        .div_i  (div_q),
        .tick_o (tick)
    );

    // tx_d is the line level for the next cycle, so tx_q changes with the state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d   = PARITY;
                            bit_cnt_d = '0;
                            tx_d      = par_q;
                        end else begin
                            state_d   = STOP;
                            bit_cnt_d = stop2_q ? CNT_ONE : '0;
                            tx_d      = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                        tx_d      = shift_d[0];
                    end
                end
            end
            PARITY: begin
                tx_d = par_q;
                if (tick) begin
                    state_d   = STOP;
                    bit_cnt_d = stop2_q ? CNT_ONE : '0;
                    tx_d      = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                // bit_cnt counts remaining stop periods down to zero.
                if (tick) begin
                    if (bit_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= DIV_ONE;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            if (accept) begin
                shift_q  <= s_if.data_in_i;
                par_q    <= (^s_if.data_in_i) ^ parity_odd_i;
                par_en_q <= parity_en_i;
                stop2_q  <= stop2_i;
                div_q    <= (clk_div_i == '0) ? DIV_ONE : clk_div_i;
            end else begin
                shift_q <= shift_d;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: a frame-level line model checked every cycle,
// plus directed frames with hand-computed lengths and bit levels.
module tb_uart_tx_stream;

    localparam int DW   = 8;
    localparam int DIVW = 16;

    logic            clk     = 1'b0;
    logic            arst    = 1'b1;
    logic [DIVW-1:0] clk_div = 16'd4;
    logic            pen     = 1'b0;
    logic            podd    = 1'b0;
    logic            s2      = 1'b0;
    logic            tx;
    logic            busy;

    uart_tx_stream_if #(.DATA_WIDTH(DW)) s_if ();

    uart_tx_stream #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .clk_div_i    (clk_div),
        .parity_en_i  (pen),
        .parity_odd_i (podd),
        .stop2_i      (s2),
        .s_if         (s_if.slave),
        .tx_o         (tx),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_bad  = 0;
    int         hs_cnt = 0;
    int         cyc    = 0;
    int         acc_t[$];
    logic       exp_q[$];
    logic       cap[$];
    logic [7:0] src_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Expected line levels for one whole frame, one entry per clock cycle.
    task automatic push_frame(input logic [7:0] w, input int div, input logic pe,
                              input logic po, input logic st2);
        logic lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < DW; i++) lv.push_back(w[i]);
        if (pe) lv.push_back((^w) ^ po);
        lv.push_back(1'b1);
        if (st2) lv.push_back(1'b1);
        foreach (lv[i]) begin
            for (int k = 0; k < div; k++) exp_q.push_back(lv[i]);
        end
    endtask

    always @(negedge clk) begin
        logic rdy_exp;
        logic e;
        cyc++;
        if (arst) begin
            exp_q.delete();
            chk("rst_tx", tx, 1);
            chk("rst_busy", busy, 0);
            chk("rst_ready", s_if.data_in_ready_o, 0);
        end else begin
            rdy_exp = (exp_q.size() == 0);
            chk("ready", s_if.data_in_ready_o, rdy_exp);
            chk("busy", busy, !rdy_exp);
            if (!rdy_exp) begin
                e = exp_q.pop_front();
                chk("tx", tx, e);
            end else begin
                chk("tx_idle", tx, 1);
            end
            if (rdy_exp && s_if.data_in_valid_i)
                push_frame(s_if.data_in_i, (clk_div == 0) ? 1 : int'(clk_div), pen, podd, s2);
            if (s_if.data_in_valid_i && s_if.data_in_ready_o) begin
                hs_cnt++;
                acc_t.push_back(cyc);
            end
        end
    end

    // Present src_q as a FIFO stream; returns 1 ns after the last accept edge.
    task automatic send_q();
        bit got;
        @(posedge clk); #1;
        while (src_q.size() > 0) begin
            s_if.data_in_i       = src_q[0];
            s_if.data_in_valid_i = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (s_if.data_in_ready_o) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                chk("accept_timeout", 0, 1);
                src_q.delete();
            end else begin
                @(posedge clk); #1;
                void'(src_q.pop_front());
            end
        end
        s_if.data_in_valid_i = 1'b0;
    endtask

    task automatic capture(output int len);
        bit done;
        cap.delete();
        len  = 0;
        done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy) begin
                cap.push_back(tx);
                len++;
            end else begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("busy_timeout", 0, 1);
    endtask

    task automatic frame(input logic [7:0] w, output int len);
        src_q.push_back(w);
        send_q();
        capture(len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         len;
        int         hs0;
        int         t0;
        logic [0:9] pat;

        s_if.data_in_i       = 8'h3C;
        s_if.data_in_valid_i = 1'b1;

        // Reset held 3 cycles with valid high: nothing may be accepted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_handshake", hs_cnt, 0);
        s_if.data_in_valid_i = 1'b0;
        arst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", s_if.data_in_ready_o, 1);

        // Basic frame 0xA5 at div 4.
        clk_div = 16'd4; pen = 1'b0; podd = 1'b0; s2 = 1'b0;
        frame(8'hA5, len);
        chk("basic_len", len, 40);
        pat = 10'b0101001011;
        for (int i = 0; i < 10; i++) begin
            chk("basic_bit_first", cap[4*i], pat[i]);
            chk("basic_bit_last", cap[4*i+3], pat[i]);
        end
        chk("basic_ready_41", s_if.data_in_ready_o, 1);

        // Parity at div 2: even then odd, then two stop bits.
        clk_div = 16'd2; pen = 1'b1; podd = 1'b0;
        frame(8'hA5, len);
        chk("even_len", len, 22);
        chk("even_parity", cap[18], 0);
        podd = 1'b1;
        frame(8'hA5, len);
        chk("odd_len", len, 22);
        chk("odd_parity", cap[18], 1);
        podd = 1'b0; s2 = 1'b1;
        frame(8'hA5, len);
        chk("stop2_len", len, 24);
        for (int i = 20; i < 24; i++) chk("stop2_level", cap[i], 1);

        // Back-to-back stream at div 1.
        clk_div = 16'd1; pen = 1'b0; s2 = 1'b0;
        hs0 = hs_cnt;
        t0  = acc_t.size();
        src_q.push_back(8'h00);
        src_q.push_back(8'hFF);
        src_q.push_back(8'h5A);
        send_q();
        capture(len);
        chk("b2b_handshakes", hs_cnt - hs0, 3);
        chk("b2b_last_len", len, 10);
        if (acc_t.size() >= t0 + 3) begin
            chk("b2b_gap1", acc_t[t0+1] - acc_t[t0], 11);
            chk("b2b_gap2", acc_t[t0+2] - acc_t[t0+1], 11);
        end else begin
            chk("b2b_accept_log", acc_t.size() - t0, 3);
        end

        // Config changed mid-frame must not affect the frame in flight.
        clk_div = 16'd4; pen = 1'b0;
        src_q.push_back(8'h3C);
        send_q();
        clk_div = 16'd8; pen = 1'b1;
        capture(len);
        chk("cfg_hold_len", len, 40);
        frame(8'h81, len);
        chk("cfg_next_len", len, 88);

        // Divisor 0 acts as 1.
        clk_div = 16'd0; pen = 1'b0;
        frame(8'h55, len);
        chk("div0_len", len, 10);

        // Reset during DATA bit 3, then a clean frame.
        clk_div = 16'd4;
        src_q.push_back(8'hC3);
        send_q();
        repeat (17) @(posedge clk);
        #1;
        chk("pre_abort_busy", busy, 1);
        arst = 1'b1;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(negedge clk);
        chk("abort_ready", s_if.data_in_ready_o, 1);
        frame(8'h96, len);
        chk("post_abort_len", len, 40);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
